fdiv_seq: RTL
=============

# fdiv_seq

Iterative, parametrised IEEE-754 floating-point divider producing one quotient bit per cycle, with valid/ready handshakes on both sides. It supports binary32 (N=32) and binary64 (N=64), round-to-nearest-even, full special-value handling and exception flags. It sits in the FP datapath next to the adders and multipliers as the multi-cycle division unit. Only one operation is in flight at a time.

## Interface
- N, 32: operand width; only 32 or 64 are legal.
- EXP_W, 8 if N=32 else 11: exponent width (derived, not overridden).
- MAN_W, 23 if N=32 else 52: stored fraction width (derived).
- BIAS, 2^(EXP_W-1)-1: exponent bias (derived).
- Q_BITS, MAN_W+3: quotient bits generated per operation (1 integer, MAN_W fraction, guard, round).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b are valid.
- in_ready  output  1  divider can accept operands.
- a  input  N  dividend.
- b  input  N  divisor.
- out_valid  output  1  out/flags are valid.
- out_ready  input  1  consumer accepts the result.
- out  output  N  quotient a/b.
- flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact}.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid, latch the operands and classify them, then go to DIVIDE. If the operands are special, go straight to DONE.
  - DIVIDE: runs for Q_BITS cycles. Restoring division of {1,fa} by {1,fb}. The remainder register is MAN_W+2 bits and the divisor register is MAN_W+1 bits. Each cycle: trial-subtract, shift the quotient bit in, restore if negative.
  - NORM: runs for 1 cycle. Normalise, round, and check range.
  - DONE: holds out/flags stable with out_valid=1 until out_ready is seen.
- Subnormal inputs (exp=0, fraction≠0) are flushed to signed zero before classification.
- Sign is always a.sign XOR b.sign, except for NaN results.
- Special cases, in priority order:
  - Any NaN operand gives the canonical qNaN 0x7FC00000 (or 0x7FF8000000000000 for N=64). invalid is set if that NaN is signalling (fraction MSB=0).
  - 0/0 or inf/inf gives qNaN with invalid.
  - inf/finite gives signed inf.
  - finite/inf gives signed zero.
  - nonzero/0 gives signed inf with div_by_zero.
  - 0/nonzero gives signed zero.
- Exponent:
  - e = ea − eb + BIAS, computed signed in EXP_W+2 bits.
  - If the quotient integer bit is 0, shift the quotient left 1 and subtract 1 from e.
- Rounding:
  - RNE on guard, round, and sticky (sticky = remainder≠0).
  - A carry out of the mantissa increments e.
  - inexact = guard|round|sticky.
- Range checks:
  - If e ≥ 2^EXP_W−1: result is signed inf; set overflow and inexact.
  - If e ≤ 0: result is signed zero (flush); set underflow and inexact.
- flags are zero for all results not listed above.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, out=0, flags=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after.
- Accept handshake: in_valid & in_ready at edge t.
- Normal operands:
  - DIVIDE occupies t+1..t+Q_BITS, and NORM is at t+Q_BITS+1.
  - out_valid rises at t+Q_BITS+2, which is t+28 for N=32 and t+57 for N=64.
- Special operands: out_valid rises at t+1.
- in_ready is 0 from t+1 until the cycle after the output handshake.
  - The output handshake is out_valid & out_ready at an edge.
  - There is no same-cycle accept/release bypass.
- With out_ready low, out/flags/out_valid are held indefinitely, unchanged.
- a/b may change freely after acceptance; only the latched copies are used.
- rst asserted in any state aborts the operation. The next cycle is IDLE with the reset values above, and no result is produced.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) → out 0x40400000, flags 0, out_valid exactly 28 cycles after accept.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAB, inexact only.
- 0x3F800000 / 0x00000000 → 0x7F800000, div_by_zero, valid at t+1. Also 0x00000000 / 0x00000000 → 0x7FC00000, invalid.
- 0x7F000000 / 0x3E800000 → 0x7F800000 with overflow+inexact. Also 0x00800000 / 0x40800000 → 0x00000000 with underflow+inexact.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out stays stable and in_ready stays 0. Raise out_ready, then in_ready=1 on the next cycle and back-to-back ops complete.
- Reset at cycle 10 of a DIVIDE → out_valid never asserts for that op. The next op, 0xC0000000 / 0x3F000000, gives 0xC0800000. Repeat one case with N=64: 0x4018000000000000 / 0x4000000000000000 → 0x4008000000000000 at t+57.

Source files
------------

// File: rtl/fdiv_seq.sv
// Iterative IEEE-754 divider (binary32 / binary64), one quotient bit per
// cycle, round-to-nearest-even, valid/ready handshake on input and output.
module fdiv_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic [4:0]   flags
);

  localparam int EXP_W  = (N == 64) ? 11 : 8;
  localparam int MAN_W  = (N == 64) ? 52 : 23;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int Q_BITS = MAN_W + 3;
  localparam int EW     = EXP_W + 2;
  localparam int CNT_W  = $clog2(Q_BITS);

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;
  localparam logic [N-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic [MAN_W+1:0]      rem_q, rem_d;
  logic [MAN_W:0]        div_q, div_d;
  logic [Q_BITS-1:0]     quo_q, quo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N-1:0]          out_q, out_d;
  logic [4:0]            flags_q, flags_d;

  logic [EXP_W-1:0]      ea, eb;
  logic [MAN_W-1:0]      fa, fb;
  logic                  a_zero, a_inf, a_nan, a_snan;
  logic                  b_zero, b_inf, b_nan, b_snan;
  logic                  sign_in;

  logic [MAN_W+2:0]      trial;
  logic [MAN_W+1:0]      rem_sel;
  logic                  q_bit;

  logic [Q_BITS-1:0]     quo_n;
  logic signed [EW-1:0]  e_n, e_r;
  logic [MAN_W:0]        mant;
  logic [MAN_W+1:0]      mant_r;
  logic                  guard, rnd, sticky, rup, carry, inexact;
  logic [MAN_W-1:0]      frac;

  // Operand field split and classification; subnormals count as zero.
  always_comb begin
    ea      = a[N-2:MAN_W];
    eb      = b[N-2:MAN_W];
    fa      = a[MAN_W-1:0];
    fb      = b[MAN_W-1:0];
    a_zero  = (ea == '0);
    b_zero  = (eb == '0);
    a_inf   = (ea == '1) && (fa == '0);
    b_inf   = (eb == '1) && (fb == '0);
    a_nan   = (ea == '1) && (fa != '0);
    b_nan   = (eb == '1) && (fb != '0);
    a_snan  = a_nan && !fa[MAN_W-1];
    b_snan  = b_nan && !fb[MAN_W-1];
    sign_in = a[N-1] ^ b[N-1];
  end

  // One restoring-division step: trial subtract, keep or restore, shift.
  always_comb begin
    trial   = {1'b0, rem_q} - {2'b00, div_q};
    q_bit   = !trial[MAN_W+2];
    rem_sel = q_bit ? trial[MAN_W+1:0] : rem_q;
  end

  // Normalise, round to nearest even, and fold the rounding carry into e.
  // A leading 0 quotient bit is dropped by a left shift; the lost bit is
  // implied by the remainder, so folding it into sticky keeps RNE exact.
  always_comb begin
    quo_n   = quo_q[Q_BITS-1] ? quo_q : (quo_q << 1);
    e_n     = quo_q[Q_BITS-1] ? exp_q : (exp_q - {{(EW-1){1'b0}}, 1'b1});
    mant    = quo_n[Q_BITS-1:2];
    guard   = quo_n[1];
    rnd     = quo_n[0];
    sticky  = (rem_q != '0);
    inexact = guard | rnd | sticky;
    rup     = guard & (rnd | sticky | mant[0]);
    mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rup};
    carry   = mant_r[MAN_W+1];
    e_r     = e_n + {{(EW-1){1'b0}}, carry};
    frac    = carry ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  end

  // Control FSM next-state and datapath register updates.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = sign_in;
          exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
          rem_d   = {1'b0, 1'b1, fa};
          div_d   = {1'b1, fb};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DONE;
          if (a_nan || b_nan) begin
            out_d   = QNAN;
            flags_d = {a_snan | b_snan, 4'b0000};
          end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            out_d   = QNAN;
            flags_d = 5'b10000;
          end else if (a_inf) begin
            out_d   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = '0;
          end else if (b_inf) begin
            out_d   = {sign_in, {(N-1){1'b0}}};
            flags_d = '0;
          end else if (b_zero) begin
            out_d   = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 5'b01000;
          end else if (a_zero) begin
            out_d   = {sign_in, {(N-1){1'b0}}};
            flags_d = '0;
          end else begin
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        quo_d = {quo_q[Q_BITS-2:0], q_bit};
        rem_d = rem_sel << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(Q_BITS - 1)) begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        state_d = S_DONE;
        if (e_r >= E_MAX) begin
          out_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 5'b00101;
        end else if (e_r <= E_ZERO) begin
          out_d   = {sign_q, {(N-1){1'b0}}};
          flags_d = 5'b00011;
        end else begin
          out_d   = {sign_q, e_r[EXP_W-1:0], frac};
          flags_d = {4'b0000, inexact};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign flags     = flags_q;

endmodule
